// File: rtl/button_gesture_decoder_pkg.sv
// Shared definitions for button gesture consumers: FSM state encodings,
// default timing constants and the pressed-level polarity.
package button_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HOLD = 3'd4
    } state_t;

    localparam int DEF_LONG_CYCLES   = 500;
    localparam int DEF_GAP_CYCLES    = 200;
    localparam int DEF_REPEAT_CYCLES = 100;
    localparam int DEF_CNT_W         = 16;

    localparam logic PRESSED = 1'b1;

endpackage

// File: rtl/button_gesture_decoder_if.sv
// Button level in, gesture event pulses out. The decoder takes the slave side;
// whoever supplies the level and consumes the events takes the master side.
interface button_gesture_decoder_if;
    logic btn_level;
    logic short_press;
    logic long_press;
    logic double_press;
    logic repeat_press;
    logic busy;

    modport master (
        output btn_level,
        input  short_press, long_press, double_press, repeat_press, busy
    );

    modport slave (
        input  btn_level,
        output short_press, long_press, double_press, repeat_press, busy
    );
endinterface

// File: rtl/button_gesture_decoder_edge_detect.sv
// Registers the previous level and flags rising/falling transitions. The reset
// value is a parameter so a level held through reset can be made edge-free.
module edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise,
    output logic fall
);
    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) prev <= RESET_VAL;
        else     prev <= level;
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;
endmodule

// File: rtl/button_gesture_decoder.sv
// Classifies debounced presses into short / long / double / auto-repeat
// single-cycle pulses using one shared cycle counter.
import button_pkg::*;

module button_gesture_decoder #(
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    button_gesture_decoder_if.slave bus
);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             rise, fall, pressed;
    logic             short_n, long_n, double_n, repeat_n;

    // Reset value 1: a button already held when reset releases is not a press.
    edge_detect #(.RESET_VAL(PRESSED)) u_edge (
        .clk   (clk),
        .rst   (rst),
        .level (bus.btn_level),
        .rise  (rise),
        .fall  (fall)
    );

    assign pressed = (bus.btn_level == PRESSED);

    // NOTE: every variable is given a default first so no path infers a latch.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        short_n  = 1'b0;
        long_n   = 1'b0;
        double_n = 1'b0;
        repeat_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_n = PRESS1;
                    cnt_n   = CNT_ONE;
                end
            end
            PRESS1: begin
                if (fall) begin
                    state_n = WAIT2;
                    cnt_n   = CNT_ONE;
                end else if (pressed) begin
                    if (cnt == LONG_LAST) begin
                        long_n  = 1'b1;
                        state_n = LONG_HOLD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            WAIT2: begin
                // A rise on the gap-completing sample is a double, not a short.
                if (rise) begin
                    double_n = 1'b1;
                    state_n  = PRESS2;
                    cnt_n    = '0;
                end else if (!pressed) begin
                    if (cnt == GAP_LAST) begin
                        short_n = 1'b1;
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            PRESS2: begin
                if (fall) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            LONG_HOLD: begin
                if (fall) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (pressed) begin
                    if (cnt == REPEAT_LAST) begin
                        repeat_n = 1'b1;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.short_press  <= 1'b0;
            bus.long_press   <= 1'b0;
            bus.double_press <= 1'b0;
            bus.repeat_press <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            bus.short_press  <= short_n;
            bus.long_press   <= long_n;
            bus.double_press <= double_n;
            bus.repeat_press <= repeat_n;
            bus.busy         <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_button_gesture_decoder.sv
// Directed bench for button_gesture_decoder with LONG=20, GAP=10, REPEAT=8.
// Each step() drives one sample; outputs are read 1 time unit after the edge.
module tb_button_gesture_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    button_gesture_decoder_if bus ();

    button_gesture_decoder #(
        .LONG_CYCLES   (20),
        .GAP_CYCLES    (10),
        .REPEAT_CYCLES (8),
        .CNT_W         (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    int idx;
    int n_short, n_long, n_double, n_repeat, n_multi, n_busy;
    int last_short, last_long, last_double, first_repeat, last_repeat;
    logic busy_hist [0:127];

    task automatic check(input string tag, input int got, input int exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        idx = 0;
        n_short = 0; n_long = 0; n_double = 0; n_repeat = 0;
        n_multi = 0; n_busy = 0;
        last_short = -1; last_long = -1; last_double = -1;
        first_repeat = -1; last_repeat = -1;
        for (int i = 0; i < 128; i++) busy_hist[i] = 1'b0;
    endtask

    task automatic step(input logic lvl, input logic r);
        int npulse;
        @(negedge clk);
        bus.btn_level = lvl;
        rst = r;
        @(posedge clk);
        #1;
        idx++;
        npulse = 0;
        if (bus.short_press)  begin n_short++;  last_short  = idx; npulse++; end
        if (bus.long_press)   begin n_long++;   last_long   = idx; npulse++; end
        if (bus.double_press) begin n_double++; last_double = idx; npulse++; end
        if (bus.repeat_press) begin
            n_repeat++;
            if (first_repeat < 0) first_repeat = idx;
            last_repeat = idx;
            npulse++;
        end
        if (npulse > 1) n_multi++;
        if (bus.busy) n_busy++;
        if (idx < 128) busy_hist[idx] = bus.busy;
    endtask

    task automatic run(input logic lvl, input int n);
        for (int i = 0; i < n; i++) step(lvl, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        run(1'b0, 3);
    endtask

    initial begin
        bus.btn_level = 1'b0;
        clear_stats();

        // Reset state
        step(1'b0, 1'b1);
        check("rst_short",  int'(bus.short_press), 0);
        check("rst_long",   int'(bus.long_press), 0);
        check("rst_double", int'(bus.double_press), 0);
        check("rst_repeat", int'(bus.repeat_press), 0);
        check("rst_busy",   int'(bus.busy), 0);
        do_reset();

        // 1: short press
        clear_stats();
        run(1'b1, 5); run(1'b0, 15);
        check("t1_short_cnt", n_short, 1);
        check("t1_short_at", last_short, 15);
        check("t1_busy_before", int'(busy_hist[14]), 1);
        check("t1_busy_drop", int'(busy_hist[15]), 0);
        check("t1_others", n_long + n_double + n_repeat, 0);

        // 2: double press
        do_reset(); clear_stats();
        run(1'b1, 5); run(1'b0, 4); run(1'b1, 6); run(1'b0, 15);
        check("t2_double_cnt", n_double, 1);
        check("t2_double_at", last_double, 10);
        check("t2_short_cnt", n_short, 0);
        check("t2_busy_held", int'(busy_hist[15]), 1);
        check("t2_busy_rel", int'(busy_hist[16]), 0);

        // 3: long press with repeats
        do_reset(); clear_stats();
        run(1'b1, 40); run(1'b0, 15);
        check("t3_long_cnt", n_long, 1);
        check("t3_long_at", last_long, 20);
        check("t3_repeat_cnt", n_repeat, 2);
        check("t3_repeat_first", first_repeat, 28);
        check("t3_repeat_last", last_repeat, 36);
        check("t3_short_cnt", n_short, 0);
        check("t3_busy_rel", int'(busy_hist[41]), 0);

        // 4a: 19 high samples -> short
        do_reset(); clear_stats();
        run(1'b1, 19); run(1'b0, 15);
        check("t4a_short_at", last_short, 29);
        check("t4a_long_cnt", n_long, 0);

        // 4b: 20 high samples -> long
        do_reset(); clear_stats();
        run(1'b1, 20); run(1'b0, 5);
        check("t4b_long_at", last_long, 20);
        check("t4b_short_cnt", n_short, 0);

        // 4c: 9-sample gap -> double
        do_reset(); clear_stats();
        run(1'b1, 5); run(1'b0, 9); run(1'b1, 3); run(1'b0, 5);
        check("t4c_double_at", last_double, 15);
        check("t4c_short_cnt", n_short, 0);

        // 4d: 10-sample gap -> short, then a fresh PRESS1
        do_reset(); clear_stats();
        run(1'b1, 5); run(1'b0, 10); run(1'b1, 3); run(1'b0, 12);
        check("t4d_short_cnt", n_short, 2);
        check("t4d_short_last", last_short, 28);
        check("t4d_double_cnt", n_double, 0);
        check("t4d_busy_new", int'(busy_hist[16]), 1);

        // 5: held through reset is not a press
        clear_stats();
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
        run(1'b1, 30);
        check("t5_pulses", n_short + n_long + n_double + n_repeat, 0);
        check("t5_busy", n_busy, 0);
        run(1'b0, 3); run(1'b1, 5); run(1'b0, 12);
        check("t5_short_cnt", n_short, 1);
        check("t5_short_at", last_short, 51);

        // 6: reset mid-gap discards the pending short
        do_reset(); clear_stats();
        run(1'b1, 5); run(1'b0, 3);
        step(1'b0, 1'b1);
        check("t6_busy_rst", int'(bus.busy), 0);
        run(1'b0, 20);
        check("t6_short_cnt", n_short, 0);
        check("t6_busy_after", int'(busy_hist[10]), 0);
        check("t6_pulses", n_long + n_double + n_repeat, 0);

        check("multi_pulse", n_multi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
